// File: rtl/map_access_arbiter.sv
// map_access_arbiter
//   Round-robin arbiter sharing the single-port map/terrain RAM among N
//   game-object requesters. Each grant reads the addressed map cell and
//   answers with a one-cycle ACK or NACK pulse:
//     query (req_type=0): ACK if the cell is free.
//     claim (req_type=1): ACK if the cell is free (owner ID is written) or
//                         already owned by the requester; NACK otherwise.
//   Cell encoding: 0 = free, k = owned by requester k-1.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   req          per-requester request level
//   req_type     per-requester type (0=query, 1=claim)
//   req_content  per-requester 8-bit cell address, requester i at [8i+7:8i]
//   ACK / NACK   one-hot, one-cycle response pulses
//   mem_en, mem_we, mem_addr, mem_wdata   map RAM command
//   mem_rdata    map RAM read data, valid one cycle after mem_en
//   busy         high while a transaction is in flight
//   grant_id     index of current or last granted requester
//
// Optional build macro ARB_STATS_EN adds saturating 16-bit counters
//   nack_cnt (NACK pulses) and grant_cnt (transactions granted).

module map_access_arbiter #(
  parameter int N      = 4,
  parameter int ID_W   = 2,
  parameter int CELL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      req_type,
  input  logic [8*N-1:0]    req_content,
  output logic [N-1:0]      ACK,
  output logic [N-1:0]      NACK,
  output logic              mem_en,
  output logic              mem_we,
  output logic [7:0]        mem_addr,
  output logic [CELL_W-1:0] mem_wdata,
  input  logic [CELL_W-1:0] mem_rdata,
  output logic              busy,
  output logic [ID_W-1:0]   grant_id
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       nack_cnt,
  output logic [15:0]       grant_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] CHK  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam int unsigned NU = N;

  logic [1:0]        state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   idx;
  logic              typ;

  logic              found;
  logic [ID_W-1:0]   win_idx;
  logic              win_type;
  logic [7:0]        win_addr;
  int unsigned       best;

  logic [CELL_W-1:0] own_val;
  logic              cell_free;
  logic              cell_own;
  logic [N-1:0]      idx_onehot;

  // Round-robin pick: each requester's distance from ptr+1 (mod N) is its
  // priority; smallest distance among active requests wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_type = 1'b0;
    win_addr = '0;
    best     = 0;
    for (int unsigned i = 0; i < NU; i++) begin
      int unsigned d;
      d = (i + NU - 1 - 32'(ptr)) % NU;
      if (req[i] && (!found || d < best)) begin
        found    = 1'b1;
        best     = d;
        win_idx  = ID_W'(i);
        win_type = req_type[i];
        win_addr = req_content[8*i +: 8];
      end
    end
  end

  always_comb begin
    own_val    = CELL_W'(idx) + CELL_W'(1);
    cell_free  = (mem_rdata == '0);
    cell_own   = (mem_rdata == own_val);
    idx_onehot = N'(1) << idx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      typ       <= 1'b0;
      ACK       <= '0;
      NACK      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
`ifdef ARB_STATS_EN
      nack_cnt  <= '0;
      grant_cnt <= '0;
`endif
    end else begin
      ACK  <= '0;
      NACK <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            idx      <= win_idx;
            typ      <= win_type;
            grant_id <= win_idx;
            mem_en   <= 1'b1;
            mem_addr <= win_addr;
            busy     <= 1'b1;
            state    <= RD;
`ifdef ARB_STATS_EN
            if (grant_cnt != '1) grant_cnt <= grant_cnt + 16'd1;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        RD: begin
          mem_en <= 1'b0;
          state  <= CHK;
        end
        CHK: begin
          if (cell_free || (typ && cell_own)) begin
            ACK <= idx_onehot;
            // Free cell on a claim: write the owner ID to the address still
            // held on mem_addr so it lands in the same cycle as the ACK.
            if (typ && cell_free) begin
              mem_en    <= 1'b1;
              mem_we    <= 1'b1;
              mem_wdata <= own_val;
            end
          end else begin
            NACK <= idx_onehot;
`ifdef ARB_STATS_EN
            if (nack_cnt != '1) nack_cnt <= nack_cnt + 16'd1;
`endif
          end
          state <= RESP;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          ptr    <= idx;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_access_arbiter.sv
// Testbench for map_access_arbiter: a behavioural map RAM, directed
// stimulus pushing hand-computed expected responses into a scoreboard queue,
// and a monitor that pops and compares on every ACK/NACK pulse.

module tb_map_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  req_type = '0;
  logic [31:0] req_content = '0;
  logic [3:0]  ACK;
  logic [3:0]  NACK;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata = '0;
  logic        busy;
  logic [1:0]  grant_id;
`ifdef ARB_STATS_EN
  logic [15:0] nack_cnt;
  logic [15:0] grant_cnt;
`endif

  map_access_arbiter #(.N(4), .ID_W(2), .CELL_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_type(req_type),
    .req_content(req_content), .ACK(ACK), .NACK(NACK),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .grant_id(grant_id)
`ifdef ARB_STATS_EN
    , .nack_cnt(nack_cnt), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Map RAM: read-first, registered read data.
  logic [3:0] ram [256] = '{default: 4'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       idx;
    bit       ack;
    bit       we;
    bit [7:0] addr;
    bit [3:0] wdata;
    int       at;
  } exp_t;

  exp_t q[$];
  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int idx, input bit ack, input bit we,
                      input bit [7:0] addr, input bit [3:0] wdata, input int at);
    exp_t e;
    e.idx = idx; e.ack = ack; e.we = we; e.addr = addr; e.wdata = wdata; e.at = at;
    q.push_back(e);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if ((ACK | NACK) != 4'b0) begin
        if (q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_pulse: ACK=%b NACK=%b, expected no pulse", ACK, NACK);
        end else begin
          exp_t e;
          logic [3:0] oh;
          e  = q.pop_front();
          oh = 4'b0001 << e.idx;
          check("ack_vec",  int'(ACK),  e.ack ? int'(oh) : 0);
          check("nack_vec", int'(NACK), e.ack ? 0 : int'(oh));
          check("resp_cycle", cyc, e.at);
          check("grant_id", int'(grant_id), e.idx);
          check("busy_in_resp", int'(busy), 1);
          check("mem_we", int'(mem_we), int'(e.we));
          check("mem_en", int'(mem_en), int'(e.we));
          if (e.we) begin
            check("mem_addr", int'(mem_addr), int'(e.addr));
            check("mem_wdata", int'(mem_wdata), int'(e.wdata));
          end
        end
      end else if (mem_we) begin
        nvec++;
        nfail++;
        $display("FAIL stray_write: mem_we=1 addr=%0h outside a response, expected 0", mem_addr);
      end
    end
  end

  // Hold req=mask until npulses responses have been seen, then drop.
  task automatic run(input logic [3:0] mask, input logic [3:0] types,
                     input logic [31:0] content, input int npulses);
    int seen = 0;
    int t = 0;
    req_type    = types;
    req_content = content;
    req         = mask;
    while (seen < npulses && t < 200) begin
      @(negedge clk);
      t++;
      if ((ACK | NACK) != 4'b0) seen++;
    end
    if (seen < npulses) check("response_timeout", seen, npulses);
    req = '0;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ACK"}, int'(ACK), 0);
    check({tag, "_NACK"}, int'(NACK), 0);
    check({tag, "_mem_en"}, int'(mem_en), 0);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_grant_id"}, int'(grant_id), 0);
  endtask

  initial begin
    int c0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Query free cell 0x35 by requester 0 -> ACK, no write
    c0 = cyc; push(0, 1, 0, 8'h35, 4'h0, c0 + 3);
    run(4'b0001, 4'b0000, 32'h0000_0035, 1);
    // Claim free cell 0x12 by requester 1 -> ACK, write 2
    c0 = cyc; push(1, 1, 1, 8'h12, 4'h2, c0 + 3);
    run(4'b0010, 4'b0010, 32'h0000_1200, 1);
    check("ram_12_owned", int'(ram[8'h12]), 2);
    // Claim 0x12 by requester 2 -> NACK (owned by 1)
    c0 = cyc; push(2, 0, 0, 8'h12, 4'h0, c0 + 3);
    run(4'b0100, 4'b0100, 32'h0012_0000, 1);
    // Query occupied 0x12 by requester 0 -> NACK
    c0 = cyc; push(0, 0, 0, 8'h12, 4'h0, c0 + 3);
    run(4'b0001, 4'b0000, 32'h0000_0012, 1);
    // Claim 0x12 by requester 3 -> NACK
    c0 = cyc; push(3, 0, 0, 8'h12, 4'h0, c0 + 3);
    run(4'b1000, 4'b1000, 32'h1200_0000, 1);
`ifdef ARB_STATS_EN
    check("nack_cnt", int'(nack_cnt), 3);
    check("grant_cnt", int'(grant_cnt), 5);
`endif
    // Claim own cell 0x12 by requester 1 -> ACK, no write
    c0 = cyc; push(1, 1, 0, 8'h12, 4'h0, c0 + 3);
    run(4'b0010, 4'b0010, 32'h0000_1200, 1);
    check("ram_12_kept", int'(ram[8'h12]), 2);

    // Requester 3 drops req during RD -> pulse still issued
    c0 = cyc; push(3, 1, 0, 8'h35, 4'h0, c0 + 3);
    req_type = 4'b0000; req_content = 32'h3500_0000; req = 4'b1000;
    @(negedge clk);
    req = '0;
    begin
      int t = 0;
      while ((ACK | NACK) == 4'b0 && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) check("drop_timeout", t, 0);
    end
    @(negedge clk);
    check("drop_busy_after", int'(busy), 0);
    check("drop_grant_id", int'(grant_id), 3);
    @(negedge clk);
    check("drop_busy_idle", int'(busy), 0);

    // Round robin from reset: all four hold queries on free cells
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    c0 = cyc;
    push(1, 1, 0, 8'h41, 4'h0, c0 + 3);
    push(2, 1, 0, 8'h42, 4'h0, c0 + 7);
    push(3, 1, 0, 8'h43, 4'h0, c0 + 11);
    push(0, 1, 0, 8'h40, 4'h0, c0 + 15);
    push(1, 1, 0, 8'h41, 4'h0, c0 + 19);
    push(2, 1, 0, 8'h42, 4'h0, c0 + 23);
    push(3, 1, 0, 8'h43, 4'h0, c0 + 27);
    push(0, 1, 0, 8'h40, 4'h0, c0 + 31);
    run(4'b1111, 4'b0000, 32'h4342_4140, 8);

    // Reset during CHK of a claim on free cell 0x77
    req_type = 4'b0100; req_content = 32'h0077_0000; req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    rst = 1'b1; req = '0;
    @(negedge clk);
    check("ram_77_unwritten", int'(ram[8'h77]), 0);
    // Pointer back to 0: requester 1 wins over 0
    c0 = cyc;
    push(1, 1, 0, 8'h51, 4'h0, c0 + 3);
    push(0, 1, 0, 8'h50, 4'h0, c0 + 7);
    run(4'b0011, 4'b0000, 32'h0000_5150, 2);

    begin
      int t = 0;
      while (q.size() != 0 && t < 20) begin @(negedge clk); t++; end
      if (q.size() != 0) check("pending_expectations", q.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
